// File: rtl/wm_sched_pkg.sv
// rtl/wm_sched_pkg.sv - shared types, program codes and duration lookup for the wash program scheduler
package wm_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_FILL_WAIT = 3'd2,
        ST_WASH      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SPIN      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [1:0] PROG_QUICK  = 2'd0;
    localparam logic [1:0] PROG_NORMAL = 2'd1;
    localparam logic [1:0] PROG_HEAVY  = 2'd2;
    localparam logic [1:0] PROG_RSVD   = 2'd3;

    // Reserved code falls back to the quick durations; callers never load it.
    function automatic int unsigned prog_duration(
        input logic [1:0]  prog,
        input logic        want_spin,
        input int unsigned wash_quick,
        input int unsigned wash_normal,
        input int unsigned wash_heavy,
        input int unsigned spin_quick,
        input int unsigned spin_normal,
        input int unsigned spin_heavy
    );
        int unsigned wash_ticks;
        int unsigned spin_ticks;
        case (prog)
            PROG_NORMAL: begin wash_ticks = wash_normal; spin_ticks = spin_normal; end
            PROG_HEAVY:  begin wash_ticks = wash_heavy;  spin_ticks = spin_heavy;  end
            default:     begin wash_ticks = wash_quick;  spin_ticks = spin_quick;  end
        endcase
        return want_spin ? spin_ticks : wash_ticks;
    endfunction

endpackage

// File: rtl/wm_tick_counter.sv
// rtl/wm_tick_counter.sv - loadable tick-enabled counter that saturates at zero (down) or at LIMIT (up)
module wm_tick_counter #(
    parameter int unsigned     TW       = 8,
    parameter bit              COUNT_UP = 1'b0,
    parameter logic [TW-1:0]   LIMIT    = '0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          tick_i,
    output logic [TW-1:0] count_o,
    output logic          flag_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign flag_o  = COUNT_UP ? (count_q == LIMIT) : (count_q == '0);
    assign count_o = count_q;

    // A load on the same cycle as a tick wins, so the tick is dropped.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && !flag_o) begin
            count_d = COUNT_UP ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wash_program_scheduler.sv
// rtl/wash_program_scheduler.sv - sequences start, wash and spin timeouts for the washing-machine cycle FSM
module wash_program_scheduler
    import wm_sched_pkg::*;
#(
    parameter int unsigned TW          = 8,
    parameter int unsigned WASH_QUICK  = 20,
    parameter int unsigned WASH_NORMAL = 45,
    parameter int unsigned WASH_HEAVY  = 70,
    parameter int unsigned SPIN_QUICK  = 10,
    parameter int unsigned SPIN_NORMAL = 15,
    parameter int unsigned SPIN_HEAVY  = 20,
    parameter int unsigned WDOG_TICKS  = 120
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          tick_i,
    input  logic [1:0]    program_sel_i,
    input  logic          start_req_i,
    input  logic          door_close_i,
    input  logic          door_lock_i,
    input  logic          motor_on_i,
    input  logic          drained_valve_on_i,
    input  logic          drained_i,
    output logic          start_o,
    output logic          cycle_timeout_o,
    output logic          spin_timeout_o,
    output logic          busy_o,
    output logic [TW-1:0] remaining_o,
    output logic          prog_err_o,
    output logic          complete_o,
    output logic          fault_o
);

    state_t        state_q;
    logic [1:0]    prog_q;
    logic          start_q;
    logic          cycle_timeout_q;
    logic          spin_timeout_q;
    logic          busy_q;
    logic          prog_err_q;
    logic          complete_q;
    logic          fault_q;

    logic          start_ok;
    logic          drain_done;
    logic          ph_load;
    logic [TW-1:0] ph_load_val;
    logic          ph_tick;
    logic [TW-1:0] ph_cnt;
    logic          ph_zero;
    logic          wd_load;
    logic          wd_tick;
    logic          wd_expired;
    logic [TW-1:0] wd_cnt_unused;

    assign start_ok   = start_req_i && door_close_i;
    assign drain_done = drained_i && drained_valve_on_i;

    // The phase counter also consumes a tick on the edge that enters WASH or SPIN,
    // since it was already loaded on an earlier cycle.
    always_comb begin
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_tick     = 1'b0;
        wd_load     = 1'b0;
        wd_tick     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok && program_sel_i != PROG_RSVD) begin
                    ph_load     = 1'b1;
                    ph_load_val = TW'(prog_duration(program_sel_i, 1'b0,
                                      WASH_QUICK, WASH_NORMAL, WASH_HEAVY,
                                      SPIN_QUICK, SPIN_NORMAL, SPIN_HEAVY));
                end
            end
            ST_START: begin
                wd_load = door_lock_i;
            end
            ST_FILL_WAIT: begin
                wd_tick = tick_i;
                ph_tick = tick_i && motor_on_i;
            end
            ST_WASH: begin
                if (ph_zero) begin
                    ph_load     = 1'b1;
                    ph_load_val = TW'(prog_duration(prog_q, 1'b1,
                                      WASH_QUICK, WASH_NORMAL, WASH_HEAVY,
                                      SPIN_QUICK, SPIN_NORMAL, SPIN_HEAVY));
                    wd_load     = 1'b1;
                end else begin
                    ph_tick = tick_i;
                end
            end
            ST_DRAIN: begin
                wd_tick = tick_i;
                ph_tick = tick_i && drain_done;
            end
            ST_SPIN: begin
                ph_tick = tick_i;
            end
            default: begin
            end
        endcase
    end

    wm_tick_counter #(
        .TW       (TW),
        .COUNT_UP (1'b0),
        .LIMIT    ('0)
    ) u_phase_cnt (
        .clk_i      (clock_i),
        .reset_i    (reset_i),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .tick_i     (ph_tick),
        .count_o    (ph_cnt),
        .flag_o     (ph_zero)
    );

    wm_tick_counter #(
        .TW       (TW),
        .COUNT_UP (1'b1),
        .LIMIT    (TW'(WDOG_TICKS))
    ) u_wdog_cnt (
        .clk_i      (clock_i),
        .reset_i    (reset_i),
        .load_i     (wd_load),
        .load_val_i ('0),
        .tick_i     (wd_tick),
        .count_o    (wd_cnt_unused),
        .flag_o     (wd_expired)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            prog_q          <= PROG_QUICK;
            start_q         <= 1'b0;
            cycle_timeout_q <= 1'b0;
            spin_timeout_q  <= 1'b0;
            busy_q          <= 1'b0;
            prog_err_q      <= 1'b0;
            complete_q      <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            cycle_timeout_q <= 1'b0;
            spin_timeout_q  <= 1'b0;
            prog_err_q      <= 1'b0;
            complete_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        if (program_sel_i == PROG_RSVD) begin
                            prog_err_q <= 1'b1;
                        end else begin
                            prog_q  <= program_sel_i;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (door_lock_i) begin
                        start_q <= 1'b0;
                        state_q <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (motor_on_i) begin
                        state_q <= ST_WASH;
                    end else if (wd_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end
                end
                ST_WASH: begin
                    if (ph_zero) begin
                        cycle_timeout_q <= 1'b1;
                        state_q         <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q <= ST_SPIN;
                    end else if (wd_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end
                end
                ST_SPIN: begin
                    if (ph_zero) begin
                        spin_timeout_q <= 1'b1;
                        complete_q     <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b1;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_o         = start_q;
    assign cycle_timeout_o = cycle_timeout_q;
    assign spin_timeout_o  = spin_timeout_q;
    assign busy_o          = busy_q;
    assign remaining_o     = ph_cnt;
    assign prog_err_o      = prog_err_q;
    assign complete_o      = complete_q;
    assign fault_o         = fault_q;

endmodule
